// File: rtl/i2s_pkg.sv
// Shared constants and encodings for the I2S receive front end.
package i2s_pkg;

    localparam int I2S_DATA_W = 32;
    localparam int I2S_SLOT_W = 32;
    // One extra bit so the bit counter can hold the full slot count.
    localparam int I2S_CNT_W  = $clog2(I2S_SLOT_W) + 1;

    typedef enum logic {
        SRC_I2S  = 1'b0,
        SRC_BIST = 1'b1
    } src_sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit for full/empty; head word reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/i2s_rx_fifo.sv
// I2S receiver: synchronise, deserialise 32-bit slots, buffer in a FIFO with sticky overrun.
// Optional ramp generator built only when I2SI_BIST_EN is defined.
module i2s_rx_fifo
    import i2s_pkg::*;
#(
    parameter int DATA_W     = I2S_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inp_sck,
    input  logic              inp_ws,
    input  logic              inp_sd,
    input  logic              rf_i2si_en,
    input  logic              rf_mux_en,
    input  logic [DATA_W-1:0] rf_bist_start_val,
    input  logic [7:0]        rf_bist_inc,
    input  logic [DATA_W-1:0] rf_bist_up_limit,
    input  logic              trig_fifo_overrun_clr,
    input  logic              i2si_rtr,
    output logic              i2si_rts,
    output logic [DATA_W-1:0] i2si_data,
    output logic              ro_fifo_overrun,
    output logic              sync_sck,
    output logic              sync_sck_transition
);

    localparam logic [I2S_CNT_W-1:0] CNT_LAST = I2S_CNT_W'(I2S_SLOT_W - 1);
    localparam logic [I2S_CNT_W-1:0] CNT_FULL = I2S_CNT_W'(I2S_SLOT_W);
    localparam logic [I2S_CNT_W-1:0] CNT_ONE  = I2S_CNT_W'(1);

    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic ws_s1_q, ws_s2_q;
    logic sd_s1_q, sd_s2_q;
    logic sck_rise;

    logic                 ws_prev_q, ws_prev_d;
    logic [DATA_W-1:0]    sr_q, sr_d;
    logic [I2S_CNT_W-1:0] cnt_q, cnt_d;
    logic                 ser_push_q, ser_push_d;
    logic [DATA_W-1:0]    ser_word_q, ser_word_d;
    logic                 overrun_q, overrun_d;

    logic              fifo_push;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              ser_drop;

    logic              bist_active;
    logic              bist_push;
    logic [DATA_W-1:0] bist_word;

    assign sck_rise            = sck_s2_q && !sck_s3_q;
    assign sync_sck            = sck_s2_q;
    assign sync_sck_transition = sck_s2_q ^ sck_s3_q;

    // A ws change on a rising edge closes the previous word; that edge's sd is its LSB.
    always_comb begin
        ws_prev_d  = ws_prev_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ser_push_d = 1'b0;
        ser_word_d = ser_word_q;
        if (sck_rise) begin
            ws_prev_d = ws_s2_q;
            if (ws_s2_q != ws_prev_q) begin
                if (cnt_q == CNT_LAST) begin
                    ser_push_d = 1'b1;
                    ser_word_d = {sr_q[DATA_W-2:0], sd_s2_q};
                end
                cnt_d = '0;
                sr_d  = '0;
            end else if (cnt_q != CNT_FULL) begin
                sr_d  = {sr_q[DATA_W-2:0], sd_s2_q};
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        if (!rf_i2si_en) begin
            sr_d       = '0;
            cnt_d      = '0;
            ser_push_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_s3_q   <= 1'b0;
            ws_s1_q    <= 1'b0;
            ws_s2_q    <= 1'b0;
            sd_s1_q    <= 1'b0;
            sd_s2_q    <= 1'b0;
            ws_prev_q  <= 1'b0;
            sr_q       <= '0;
            cnt_q      <= '0;
            ser_push_q <= 1'b0;
            ser_word_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            sck_s1_q   <= inp_sck;
            sck_s2_q   <= sck_s1_q;
            sck_s3_q   <= sck_s2_q;
            ws_s1_q    <= inp_ws;
            ws_s2_q    <= ws_s1_q;
            sd_s1_q    <= inp_sd;
            sd_s2_q    <= sd_s1_q;
            ws_prev_q  <= ws_prev_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ser_push_q <= ser_push_d;
            ser_word_q <= ser_word_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef I2SI_BIST_EN
    logic [DATA_W-1:0] bist_val_q, bist_val_d;
    logic [DATA_W:0]   bist_sum;
    logic [DATA_W-1:0] bist_next;

    assign bist_active = rf_i2si_en && (src_sel_e'(rf_mux_en) == SRC_BIST);
    assign bist_push   = bist_active && !fifo_full;
    assign bist_word   = bist_val_q;
    assign bist_sum    = {1'b0, bist_val_q} + (DATA_W+1)'(rf_bist_inc);
    // Carry out of the word or passing the limit both restart the ramp.
    assign bist_next   = (bist_sum[DATA_W] || (bist_sum[DATA_W-1:0] > rf_bist_up_limit)) ?
                         rf_bist_start_val : bist_sum[DATA_W-1:0];

    always_comb begin
        bist_val_d = bist_val_q;
        if (!bist_active) begin
            bist_val_d = rf_bist_start_val;
        end else if (bist_push) begin
            bist_val_d = bist_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) bist_val_q <= rf_bist_start_val;
        else     bist_val_q <= bist_val_d;
    end
`else
    logic unused_bist_inputs;
    assign unused_bist_inputs = ^{rf_mux_en, rf_bist_start_val, rf_bist_inc, rf_bist_up_limit};
    assign bist_active        = 1'b0;
    assign bist_push          = 1'b0;
    assign bist_word          = '0;
`endif

    assign fifo_pop   = i2si_rts && i2si_rtr;
    assign fifo_push  = bist_active ? bist_push : ser_push_q;
    assign fifo_wdata = bist_active ? bist_word : ser_word_q;
    assign ser_drop   = ser_push_q && !bist_active && fifo_full && !fifo_pop;

    // Set has priority over a coincident clear.
    always_comb begin
        overrun_d = overrun_q;
        if (ser_drop) begin
            overrun_d = 1'b1;
        end else if (trig_fifo_overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign i2si_rts        = !fifo_empty;
    assign i2si_data       = fifo_head;
    assign ro_fifo_overrun = overrun_q;

endmodule
